// File: rtl/fifo_ser_pkg.sv
// Shared types and constants for the FIFO-fed serial transmitter.
// FIFO_SER_PARITY_EN adds the even-parity state to the FSM encoding.
package fifo_ser_pkg;

  localparam int DATA_W           = 8;
  localparam int CLKS_PER_BIT_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LOAD,
    S_START,
    S_DATA,
`ifdef FIFO_SER_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } ser_state_t;

  function automatic logic even_par(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/fifo_ser_tx_timer.sv
// Bit-period timer: bit_end is a registered tick in the last cycle of each
// CLKS_PER_BIT-long period; restart holds the count at the period start.
module ser_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic bit_end
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  assign cnt_nxt = cnt + CNT_W'(1);

  // bit_end mirrors (cnt == TERM) as a flop, so it never runs past terminal
  always_ff @(posedge clk) begin
    if (!rst_n || restart) begin
      cnt     <= '0;
      bit_end <= 1'b0;
    end else if (bit_end) begin
      cnt     <= '0;
      bit_end <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      bit_end <= (cnt_nxt == TERM);
    end
  end

endmodule

// File: rtl/fifo_ser_tx.sv
// Pops bytes from a FIFO and sends them as start/8 data LSB-first/stop frames.
// Define FIFO_SER_PARITY_EN to insert an even-parity bit before the stop bit.
module fifo_ser_tx
  import fifo_ser_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              CLEAR_N,
  input  logic              ENABLE,
  input  logic              F_EMPTY_N,
  input  logic [DATA_W-1:0] FIFO_DATA,
  output logic              FIFO_READ,
  output logic              TX,
  output logic              BUSY,
  output logic              BYTE_DONE
);

  ser_state_t        state;
  logic [DATA_W-1:0] shreg;
  logic [2:0]        bit_idx;
  logic              bit_end;
  logic              restart;
  logic              go;
`ifdef FIFO_SER_PARITY_EN
  logic              par;
`endif

  assign go      = ENABLE & F_EMPTY_N;
  // Timer is held at zero until the start bit begins
  assign restart = (state == S_IDLE) || (state == S_POP) || (state == S_LOAD);
  assign BYTE_DONE = (state == S_STOP) && bit_end;

  ser_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk     (CLK),
    .rst_n   (RESET_N & CLEAR_N),
    .restart (restart),
    .bit_end (bit_end)
  );

  always_ff @(posedge CLK) begin
    if (!RESET_N || !CLEAR_N) begin
      state     <= S_IDLE;
      TX        <= 1'b1;
      FIFO_READ <= 1'b0;
      BUSY      <= 1'b0;
      shreg     <= '0;
      bit_idx   <= '0;
`ifdef FIFO_SER_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      FIFO_READ <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go) begin
            state     <= S_POP;
            FIFO_READ <= 1'b1;
            BUSY      <= 1'b1;
          end
        end
        S_POP: state <= S_LOAD;
        S_LOAD: begin
          shreg   <= FIFO_DATA;
          bit_idx <= '0;
`ifdef FIFO_SER_PARITY_EN
          par     <= even_par(FIFO_DATA);
`endif
          TX      <= 1'b0;
          state   <= S_START;
        end
        S_START: begin
          if (bit_end) begin
            TX    <= shreg[0];
            shreg <= {1'b0, shreg[DATA_W-1:1]};
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
`ifdef FIFO_SER_PARITY_EN
              TX    <= par;
              state <= S_PARITY;
`else
              TX    <= 1'b1;
              state <= S_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              TX      <= shreg[0];
              shreg   <= {1'b0, shreg[DATA_W-1:1]};
            end
          end
        end
`ifdef FIFO_SER_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            TX    <= 1'b1;
            state <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          // Chain straight into the next pop so the inter-frame gap is POP+LOAD
          if (bit_end) begin
            if (go) begin
              state     <= S_POP;
              FIFO_READ <= 1'b1;
            end else begin
              state <= S_IDLE;
              BUSY  <= 1'b0;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          TX    <= 1'b1;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_ser_tx.sv
// Bench for fifo_ser_tx: frame-position model checked every cycle plus
// hand-computed waveform literals. Honours FIFO_SER_PARITY_EN.
module tb_fifo_ser_tx;

  localparam int CPB = 4;
`ifdef FIFO_SER_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FLEN      = NBITS * CPB;
  localparam int FRAME_CYC = 2 + FLEN;
  localparam int LAST      = FRAME_CYC - 1;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       CLEAR_N = 1'b1;
  logic       ENABLE = 1'b0;
  logic       F_EMPTY_N;
  logic [7:0] FIFO_DATA = 8'h00;
  logic       FIFO_READ, TX, BUSY, BYTE_DONE;

  fifo_ser_tx #(.CLKS_PER_BIT(CPB)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .CLEAR_N(CLEAR_N), .ENABLE(ENABLE),
    .F_EMPTY_N(F_EMPTY_N), .FIFO_DATA(FIFO_DATA), .FIFO_READ(FIFO_READ),
    .TX(TX), .BUSY(BUSY), .BYTE_DONE(BYTE_DONE)
  );

  always #5 CLK = ~CLK;

  logic [7:0] fifo_mem [64];
  int wr_cnt = 0, rd_ptr = 0;
  assign F_EMPTY_N = (wr_cnt != rd_ptr);

  int checks = 0, errors = 0;
  bit chk_en = 0;

  // model: idle, or at position pos of a frame (0 = pop cycle, 1 = load cycle)
  bit m_active = 0;
  int m_pos = 0, m_rd = 0;
  logic [7:0] m_byte = 8'h00;

  logic tx_log[$];
  int rd_cnt = 0, done_cnt = 0, busy_cyc = 0;
  int rv [8];
  int rl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_tx(bit act, int pos, logic [7:0] b);
    int k;
    if (!act || pos < 2) return 1'b1;
    k = (pos - 2) / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef FIFO_SER_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_cnt] = b;
    wr_cnt++;
  endtask

  task automatic wait_idle(input int maxc);
    bit ok = 0;
    for (int i = 0; i < maxc; i++) begin
      step(1);
      if (!BUSY && !m_active) begin ok = 1; break; end
    end
    chk("idle_wait", {31'd0, ok}, 32'd1);
  endtask

  task automatic get_runs(input int base);
    int n = 0;
    logic cur;
    for (int i = 0; i < 8; i++) begin rv[i] = 0; rl[i] = 0; end
    cur = tx_log[base];
    for (int i = base; i < tx_log.size(); i++) begin
      if (tx_log[i] === cur) rl[n]++;
      else if (n < 7) begin
        rv[n] = int'(cur); n++; cur = tx_log[i]; rl[n] = 1;
      end
    end
    rv[n] = int'(cur);
  endtask

  task automatic check_frame(input string tag, input int base, input int lo1,
                             input int hi, input int lo2);
    get_runs(base);
    chk({tag, "_lead_hi"}, rv[0], 1);
    chk({tag, "_start_len"}, rl[1], lo1);
    chk({tag, "_hi_len"}, rl[2], hi);
    chk({tag, "_lo_len"}, rl[3], lo2);
  endtask

  initial begin
    int base, r0, d0, b0, zeros;
    fork
      // model update on the same edge the DUT samples its inputs
      forever begin
        @(posedge CLK);
        if (!RESET_N || !CLEAR_N) m_active = 0;
        else if (!m_active || m_pos == LAST) begin
          if (ENABLE && F_EMPTY_N) begin
            m_active = 1; m_pos = 0;
            m_byte = (m_rd < wr_cnt) ? fifo_mem[m_rd] : 8'h00;
            m_rd++;
          end else m_active = 0;
        end else m_pos++;
      end
      // compare, log, then FIFO read-data response
      forever begin
        @(negedge CLK);
        if (chk_en) begin
          chk("tx", TX, exp_tx(m_active, m_pos, m_byte));
          chk("read", FIFO_READ, m_active && m_pos == 0);
          chk("busy", BUSY, m_active);
          chk("done", BYTE_DONE, m_active && m_pos == LAST);
          tx_log.push_back(TX);
          if (BUSY) busy_cyc++;
          if (FIFO_READ) rd_cnt++;
          if (BYTE_DONE) done_cnt++;
        end
        if (FIFO_READ === 1'b1 && rd_ptr < wr_cnt) begin
          FIFO_DATA = fifo_mem[rd_ptr];
          rd_ptr++;
        end
      end
      begin
        #2000000;
        chk("global_timeout", 0, 1);
      end
      begin
        step(2);
        chk_en = 1;
        RESET_N = 1;
        chk("rst_tx", TX, 1);
        chk("rst_busy", BUSY, 0);
        chk("rst_read", FIFO_READ, 0);
        chk("rst_done", BYTE_DONE, 0);

        // single byte 8'h01
        push(8'h01);
        base = tx_log.size(); r0 = rd_cnt; d0 = done_cnt; b0 = busy_cyc;
        ENABLE = 1; step(2); wait_idle(200); ENABLE = 0; step(2);
        chk("b01_reads", rd_cnt - r0, 1);
        chk("b01_dones", done_cnt - d0, 1);
        chk("b01_busy_len", busy_cyc - b0, FRAME_CYC);
        check_frame("b01", base, 4, 4, 28);

        // four back-to-back bytes
        push(8'h01); push(8'h02); push(8'h04); push(8'h08);
        r0 = rd_cnt; d0 = done_cnt; b0 = busy_cyc;
        ENABLE = 1; step(2); wait_idle(600); ENABLE = 0; step(2);
        chk("x4_reads", rd_cnt - r0, 4);
        chk("x4_dones", done_cnt - d0, 4);
        chk("x4_busy_len", busy_cyc - b0, 4 * FRAME_CYC);
        chk("x4_fifo_drained", rd_ptr, wr_cnt);

        // empty FIFO with ENABLE high
        base = tx_log.size(); r0 = rd_cnt;
        ENABLE = 1; step(100); ENABLE = 0;
        zeros = 0;
        for (int i = base; i < tx_log.size(); i++) if (tx_log[i] !== 1'b1) zeros++;
        chk("empty_reads", rd_cnt - r0, 0);
        chk("empty_tx_low", zeros, 0);

        // ENABLE dropped mid-frame: frame completes, no second pop
        push(8'hAA); push(8'h55);
        r0 = rd_cnt; d0 = done_cnt;
        ENABLE = 1; step(10); ENABLE = 0; wait_idle(200); step(2);
        chk("endrop_reads", rd_cnt - r0, 1);
        chk("endrop_dones", done_cnt - d0, 1);

        // CLEAR_N pulse during data bit 3 of the 8'h55 frame
        d0 = done_cnt;
        ENABLE = 1; step(20);
        ENABLE = 0; CLEAR_N = 0; step(1); CLEAR_N = 1;
        chk("clr_tx", TX, 1);
        chk("clr_busy", BUSY, 0);
        step(60);
        chk("clr_dones", done_cnt - d0, 0);

        // RESET_N low for two cycles mid-frame
        push(8'hC3);
        d0 = done_cnt;
        ENABLE = 1; step(15);
        ENABLE = 0; RESET_N = 0; step(2); RESET_N = 1;
        chk("mrst_tx", TX, 1);
        chk("mrst_read", FIFO_READ, 0);
        chk("mrst_busy", BUSY, 0);
        chk("mrst_done", BYTE_DONE, 0);
        step(60);
        chk("mrst_dones", done_cnt - d0, 0);

        // 8'h07: three ones, five zeros; odd count so even parity bit is 1
        push(8'h07);
        base = tx_log.size(); b0 = busy_cyc;
        ENABLE = 1; step(2); wait_idle(200); ENABLE = 0; step(2);
        chk("b07_busy_len", busy_cyc - b0, FRAME_CYC);
        check_frame("b07", base, 4, 12, 20);
        get_runs(base);
        base = base + rl[0];
        chk("b07_bit9_first", tx_log[base + 36], 1);
        chk("b07_bit9_last", tx_log[base + 39], 1);
`ifdef FIFO_SER_PARITY_EN
        chk("b07_frame_len", busy_cyc - b0 - 2, 44);
`endif
      end
    join_any
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_ser_tx.md
FIFO_SER_TX -- requirements
Module: fifo_ser_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4: clock cycles per serial bit, legal range 2..255.
REQ-002 SHALL have port CLK  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port RESET_N  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port CLEAR_N  input  1  synchronous active-low abort; returns block to idle.
REQ-005 SHALL have port ENABLE  input  1  permits fetching new bytes from the FIFO.
REQ-006 SHALL have port F_EMPTY_N  input  1  FIFO status; 1 = at least one byte available.
REQ-007 SHALL have port FIFO_DATA  input  8  FIFO read data; valid the cycle after READ is sampled high.
REQ-008 SHALL have port FIFO_READ  output  1  one-cycle pop strobe to the FIFO.
REQ-009 SHALL have port TX  output  1  serial line; idle level 1.
REQ-010 SHALL have port BUSY  output  1  high from pop until end of stop bit.
REQ-011 SHALL have port BYTE_DONE  output  1  one-cycle pulse in last cycle of stop bit.

Function
REQ-012 SHALL implement FSM states IDLE, POP, LOAD, START, DATA, PARITY (macro only), STOP.
REQ-013 SHALL, in IDLE, go to POP when ENABLE=1 and F_EMPTY_N=1; otherwise stay in IDLE.
REQ-014 SHALL assert FIFO_READ only in POP, for exactly one cycle, and never while F_EMPTY_N=0.
REQ-015 SHALL, in LOAD, capture FIFO_DATA into an 8-bit shift register; then go to START.
REQ-016 SHALL drive TX=0 for CLKS_PER_BIT cycles in START.
REQ-017 SHALL send 8 data bits LSB first, each held for CLKS_PER_BIT cycles, in DATA.
REQ-018 SHALL drive TX=1 for CLKS_PER_BIT cycles in STOP and pulse BYTE_DONE in its last cycle.
REQ-019 SHALL, at end of STOP, go to POP if ENABLE=1 and F_EMPTY_N=1; otherwise go to IDLE.
REQ-020 SHALL hold TX=1 in IDLE, POP and LOAD, giving a 2-cycle high gap between back-to-back frames.
REQ-021 SHALL ignore ENABLE deassertion mid-frame; the current frame completes and no new pop occurs.
REQ-022 SHALL keep BUSY=1 in every state except IDLE.
REQ-023 SHALL size the bit-cycle counter as ceil(log2(CLKS_PER_BIT)) bits and the bit index as 3 bits; no wrap beyond terminal counts.

Reset
REQ-024 SHALL, when RESET_N=0 at a clock edge, set: state IDLE, TX=1, FIFO_READ=0, BUSY=0, BYTE_DONE=0, counters 0, shift register 0.
REQ-025 SHALL give CLEAR_N=0 the same effect as RESET_N=0; RESET_N has priority; both abort a frame in progress (the byte is discarded, no BYTE_DONE).
REQ-026 SHALL apply reset/clear results on the first edge; TX=1 from the next cycle onward.

Configuration
REQ-027 SHALL, with FIFO_SER_PARITY_EN defined, insert state PARITY between DATA and STOP driving even parity (XOR of 8 data bits) for CLKS_PER_BIT cycles.
REQ-028 SHALL, without FIFO_SER_PARITY_EN, omit the PARITY state entirely and go DATA -> STOP.

Structure
REQ-029 SHALL place the FSM state enum, DATA_W=8 and the default CLKS_PER_BIT in package fifo_ser_pkg.
REQ-030 SHALL implement the bit-period counter as sub-module ser_bit_timer (inputs: clock, reset, restart; output: one-cycle bit_end tick).

Verification
REQ-031 SHALL cover: RESET_N=0 for 2 cycles mid-frame -> TX=1, FIFO_READ=0, BUSY=0, BYTE_DONE=0 afterward.
REQ-032 SHALL cover: FIFO model holding 8'h01, ENABLE=1, no parity -> one READ pulse; TX: 0 for 4, 1 for 4, 0 for 28, 1 for 4 cycles; one BYTE_DONE.
REQ-033 SHALL cover: bytes 8'h01, 8'h02, 8'h04, 8'h08 queued -> 4 READ pulses, 4 frames in order with 2-cycle high gaps, then IDLE and BUSY=0.
REQ-034 SHALL cover: F_EMPTY_N=0, ENABLE=1 for 100 cycles -> FIFO_READ never high, TX constant 1.
REQ-035 SHALL cover: CLEAR_N=0 for one cycle during data bit 3 -> TX=1 and BUSY=0 the following cycle, no BYTE_DONE.
REQ-036 SHALL cover: FIFO_SER_PARITY_EN defined, byte 8'h07 -> parity bit 1 for 4 cycles, frame length 44 cycles.
